rot_cmd_feeder: RTL and testbench

ROT_CMD_FEEDER -- requirements
Module: rot_cmd_feeder

---
 rtl/rot_cmd_feeder.sv | 59 +++++
 tb/tb_rot_cmd_feeder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rot_cmd_feeder.sv
// rot_cmd_feeder: 4-entry command FIFO feeding an external rotate-right shifter, registered result output.
// Define ROT_FEEDER_LEFT_EN to convert left-rotate commands into right-rotate amounts.
module rot_cmd_feeder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_amt,
   input  logic        in_dir,
   output logic [31:0] sh_a,
   output logic [4:0]  sh_amt,
   input  logic [31:0] sh_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  level
);
   logic [36:0] mem [4];
   logic [1:0]  rd_ptr, wr_ptr;
   logic [4:0]  r_amt;
   logic        push, pop, empty;
`ifdef ROT_FEEDER_LEFT_EN
   // rotate left by n equals rotate right by (32 - n) mod 32
   assign r_amt = in_dir ? 5'(-in_amt) : in_amt;
`else
   logic unused_dir;
   assign unused_dir = in_dir;
   assign r_amt = in_amt;
`endif
   assign empty    = level == 3'd0;
   assign in_ready = level != 3'd4;
   assign push     = in_valid && in_ready;
   assign pop      = !empty && (!out_valid || out_ready);
   assign sh_a     = empty ? 32'd0 : mem[rd_ptr][36:5];
   assign sh_amt   = empty ? 5'd0 : mem[rd_ptr][4:0];
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_data, r_amt};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= 2'd0;
         wr_ptr    <= 2'd0;
         level     <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         level <= level + 3'(push) - 3'(pop);
         if (pop) begin
            out_data  <= sh_y;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_rot_cmd_feeder.sv
// tb_rot_cmd_feeder: directed and random stimulus with a queue scoreboard and a rotate reference model.
module tb_rot_cmd_feeder;
`ifdef ROT_FEEDER_LEFT_EN
   localparam bit left_en = 1'b1;
`else
   localparam bit left_en = 1'b0;
`endif
   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, in_dir = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic [4:0]  in_amt = 5'd0;
   logic        in_ready, out_valid;
   logic [31:0] sh_a, sh_y, out_data;
   logic [4:0]  sh_amt;
   logic [2:0]  level;
   logic [63:0] sh_t;
   int          total = 0, bad = 0;
   logic [31:0] exp_q[$];

   rot_cmd_feeder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .sh_a(sh_a),
      .sh_amt(sh_amt), .sh_y(sh_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .level(level)
   );

   // behavioural stand-in for the external rotate-right shifter
   assign sh_t = {sh_a, sh_a} >> sh_amt;
   assign sh_y = sh_t[31:0];

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic dir);
      logic [63:0] t;
      if (left_en && dir) begin
         t = {d, d} << a;
         return t[63:32];
      end
      t = {d, d} >> a;
      return t[31:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] a, input logic dir);
      in_data = d; in_amt = a; in_dir = dir; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // expected results are queued at the moment a command is accepted
   always @(negedge clk) begin
      if (reset) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_data, in_amt, in_dir));
   end

   // monitor: every result handed downstream must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_extra: got %h expected no result", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      int n;
      repeat (2) step();
      reset = 1'b0;
      chk("rst_level", 32'(level), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sh_amt", 32'(sh_amt), 0);
      chk("rst_sh_a", sh_a, 0);

      out_ready = 1'b1;
      send(32'h8000_0001, 5'd1, 1'b0);
      chk("right_sh_amt", 32'(sh_amt), 1);
      chk("right_sh_a", sh_a, 32'h8000_0001);
      chk("latency_not_yet", 32'(out_valid), 0);
      step();
      chk("latency_valid", 32'(out_valid), 1);
      chk("right_data", out_data, 32'hC000_0000);
      step();
      chk("drain_valid", 32'(out_valid), 0);
      chk("drain_hold", out_data, 32'hC000_0000);

      send(32'h0000_0001, 5'd4, 1'b1);
      chk("left_sh_amt", 32'(sh_amt), left_en ? 28 : 4);
      step();
      chk("left_data", out_data, left_en ? 32'h0000_0010 : 32'h1000_0000);
      send(32'h0000_0001, 5'd0, 1'b1);
      chk("left0_sh_amt", 32'(sh_amt), 0);
      step();
      chk("left0_data", out_data, 32'h0000_0001);
      step();

      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(32'h1111_1111 * (i + 1), 5'(i * 3), 1'(i));
      chk("fill_level", 32'(level), 4);
      chk("fill_in_ready", 32'(in_ready), 0);
      chk("fill_out_valid", 32'(out_valid), 1);
      chk("fill_first", out_data, model(32'h1111_1111, 5'd0, 1'b0));
      in_data = 32'hDEAD_BEEF; in_amt = 5'd7; in_dir = 1'b0; in_valid = 1'b1;
      repeat (3) step();
      chk("wait_level", 32'(level), 4);
      chk("wait_hold", out_data, model(32'h1111_1111, 5'd0, 1'b0));
      out_ready = 1'b1;
      step();
      chk("full_pop_level", 32'(level), 3);
      step();
      in_valid = 1'b0;
      chk("full_push_level", 32'(level), 3);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stream_valid", 32'(out_valid), 1);
      end
      step();
      chk("stream_end", 32'(out_valid), 0);

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send($urandom, 5'($urandom), 1'($urandom));
      chk("mid_level", 32'(level), 3);
      chk("mid_out_valid", 32'(out_valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      repeat (5) step();
      chk("no_stale", 32'(out_valid), 0);

      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom % 4) != 0;
         in_data = $urandom;
         in_amt = 5'($urandom);
         in_dir = 1'($urandom);
         out_ready = ($urandom % 3) != 0;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((level != 0 || out_valid) && n < 20) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < 20), 1);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
